// File: rtl/divisor_ctrl.sv
// Programmable clock divider: x toggles every 'period' cycles while running, with a graceful stop.
// Optional divide-by-two output k is enabled by defining DIVISOR_CTRL_K_EN.
module divisor_ctrl #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         stop,
   input  logic [W-1:0] div_half,
   output logic         busy,
   output logic         x,
   output logic         tick,
   output logic         err
`ifdef DIVISOR_CTRL_K_EN
   ,
   output logic         k
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   state_t       state;
   logic [W-1:0] cnt;
   logic [W-1:0] period;
   logic         active;
   logic         wrap;
   logic         stopNow;
   logic         rise;
   logic         toIdle;

   // A stop seen while x is high waits for the falling toggle so the high phase is never cut short.
   assign active  = (state != IDLE);
   assign wrap    = (cnt == period - ONE);
   assign stopNow = (state == RUN) && stop && !x;
   assign rise    = active && !stopNow && wrap && !x;
   assign toIdle  = stopNow || (active && wrap && x && ((state == STOP) || stop));

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         period <= '0;
         x      <= 1'b0;
         tick   <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         tick <= rise;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (div_half != '0) begin
                     period <= div_half;
                     cnt    <= '0;
                     busy   <= 1'b1;
                     state  <= RUN;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RUN, STOP: begin
               if (toIdle) begin
                  state <= IDLE;
                  cnt   <= '0;
                  x     <= 1'b0;
                  busy  <= 1'b0;
               end else if (wrap) begin
                  cnt <= '0;
                  x   <= ~x;
               end else begin
                  cnt <= cnt + ONE;
                  if (stop) begin
                     state <= STOP;
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               x     <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DIVISOR_CTRL_K_EN
   // k flips on every rising edge of x and is cleared whenever the divider returns to IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         k <= 1'b0;
      end else if (toIdle) begin
         k <= 1'b0;
      end else if (rise) begin
         k <= ~k;
      end
   end
`endif

endmodule

// File: tb/tb_divisor_ctrl.sv
// Self-checking bench for divisor_ctrl: directed scenarios plus randomized sessions
// compared against an arithmetic model of the divided waveform.
module tb_divisor_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] div_half = '0;
   logic       busy;
   logic       x;
   logic       tick;
   logic       err;
`ifdef DIVISOR_CTRL_K_EN
   logic       k;
`endif

   int checks = 0;
   int failures = 0;

   divisor_ctrl #(.W(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .div_half (div_half),
      .busy     (busy),
      .x        (x),
      .tick     (tick),
      .err      (err)
`ifdef DIVISOR_CTRL_K_EN
      ,
      .k        (k)
`endif
   );

   always #5 clock = ~clock;

   // After n edges from the accepting edge, x has completed n/p half periods.
   function automatic logic expX(input int n, input int p);
      return ((n / p) % 2) == 1;
   endfunction

   function automatic logic expTick(input int n, input int p);
      return (n > 0) && ((n % p) == 0) && (((n / p) % 2) == 1);
   endfunction

   function automatic logic expK(input int n, input int p);
      return ((((n / p) + 1) / 2) % 2) == 1;
   endfunction

   task automatic applyStimulus(input logic s, input logic p, input logic [7:0] d);
      start    = s;
      stop     = p;
      div_half = d;
      @(posedge clock);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic eBusy, input logic eX,
                           input logic eTick, input logic eErr, input logic eK);
      checkOutput({tag, ".busy"}, busy, eBusy);
      checkOutput({tag, ".x"}, x, eX);
      checkOutput({tag, ".tick"}, tick, eTick);
      checkOutput({tag, ".err"}, err, eErr);
`ifdef DIVISOR_CTRL_K_EN
      checkOutput({tag, ".k"}, k, eK);
`else
      if (eK !== 1'bx) begin
         eK = 1'b0;
      end
`endif
   endtask

   // One full run: accept period p, request stop after nStop edges, follow until back in IDLE.
   task automatic runSession(input string tag, input int p, input int nStop, input logic withStop);
      int   n;
      logic stopping;
      logic done;
      logic doStop;
      logic xPrev;
      logic sBit;
      applyStimulus(1'b1, withStop, 8'(p));
      checkAll({tag, "/accept"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n        = 0;
      stopping = 1'b0;
      done     = 1'b0;
      while (!done) begin
         doStop = (n == nStop);
         xPrev  = expX(n, p);
         sBit   = doStop | (stopping & 1'($urandom));
         applyStimulus(1'($urandom), sBit, 8'($urandom));
         n++;
         if ((doStop && !xPrev) || ((doStop || stopping) && ((n % p) == 0))) begin
            checkAll({tag, "/stopped"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            done = 1'b1;
         end else begin
            if (doStop) begin
               stopping = 1'b1;
            end
            checkAll({tag, "/run"}, 1'b1, expX(n, p), expTick(n, p), 1'b0, expK(n, p));
         end
      end
      applyStimulus(1'b0, 1'b1, 8'($urandom));
      checkAll({tag, "/idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset held for two cycles while start and stop are also asserted.
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'd2);
      applyStimulus(1'b1, 1'b1, 8'd2);
      checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkAll("postReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      runSession("half2", 2, 9, 1'b0);

      // A zero divisor is rejected with a single err pulse.
      applyStimulus(1'b1, 1'b1, 8'd0);
      checkAll("reject", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkAll("rejectAfter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      runSession("half3StopHigh", 3, 3, 1'b0);
      runSession("half1StopLow", 1, 2, 1'b0);
      runSession("half5", 5, 12, 1'b0);

      // Reset in the middle of a high phase drops everything at once.
      applyStimulus(1'b1, 1'b0, 8'd4);
      repeat (5) applyStimulus(1'b0, 1'b0, 8'd0);
      checkAll("preReset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'd4);
      checkAll("midReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      runSession("startWithStop", 3, 7, 1'b1);
      runSession("maxPeriod", 255, 260, 1'b0);

      for (int i = 0; i < 8; i++) begin
         runSession("random", int'($urandom_range(1, 6)), int'($urandom_range(0, 20)), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
